fifo_burst_reader: RTL and testbench

- Read-side consumer for the fifo1 async FIFO, sitting in the clk2 (read) domain opposite the feature-memory writer.
- Pops a fixed-length burst from the FIFO with a proper rempty-qualified rinc handshake and buffers it in a local signed memory.
- Replays the buffer as an 8-bit valid/ready stream to the downstream weight/port_D consumer.
- Replaces ad-hoc negedge-rempty flags and read-sync counters with a single-clock FSM.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/burst_buf.sv | 32 +++
 rtl/fifo_burst_reader.sv | 109 ++++++++++
 tb/tb_fifo_burst_reader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo1 read-side burst reader and its writer-side peer.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DSIZE_DEF = 8;
    localparam int BURST_DEF = 16;
    localparam int CW_DEF    = 9;

    // Address width for a buffer of the given depth; a depth of 1 still needs one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/burst_buf.sv
// Burst buffer: one synchronous write port and one registered, enable-gated read port.
module burst_buf #(
    parameter int DSIZE = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DSIZE-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [DSIZE-1:0] rd_data
);

    logic signed [DSIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        // Write-first on a same-address collision so a one-word burst streams the fresh word.
        if (rd_en) begin
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a fixed-length burst from fifo1, buffers it, then replays it as a valid/ready stream.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int BURST = BURST_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             start,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    fill_cnt
);

    localparam int            AW       = addr_width(BURST);
    localparam logic [CW-1:0] FULL_CNT = CW'(BURST);
    localparam logic [CW-1:0] LAST_IDX = CW'(BURST - 1);

    state_t            state_reg;
    logic [CW-1:0]     rd_idx_reg;
    logic              last_fill;
    logic              xfer;
    logic              last_xfer;
    logic              buf_rd_en;
    logic [AW-1:0]     buf_rd_addr;
    logic [DSIZE-1:0]  buf_rd_data;

    assign rinc      = (state_reg == FILL) && !rempty && (fill_cnt < FULL_CNT);
    assign last_fill = rinc && (fill_cnt == LAST_IDX);
    assign xfer      = (state_reg == STREAM) && out_valid && out_ready;
    assign last_xfer = xfer && (rd_idx_reg == LAST_IDX);

    // The read register is loaded with buf[0] on the final capture and advanced only on a
    // transfer, so it holds its word for as long as the consumer stalls.
    assign buf_rd_en   = last_fill || (xfer && !last_xfer);
    assign buf_rd_addr = last_fill ? '0 : AW'(rd_idx_reg + 1'b1);
    assign out_data    = out_valid ? buf_rd_data : '0;

    burst_buf #(
        .DSIZE (DSIZE),
        .DEPTH (BURST),
        .AW    (AW)
    ) u_buf (
        .clk     (rclk),
        .wr_en   (rinc),
        .wr_addr (fill_cnt[AW-1:0]),
        .wr_data (rdata),
        .rd_en   (buf_rd_en),
        .rd_addr (buf_rd_addr),
        .rd_data (buf_rd_data)
    );

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_reg  <= IDLE;
            fill_cnt   <= '0;
            rd_idx_reg <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= FILL;
                        fill_cnt  <= '0;
                        busy      <= 1'b1;
                    end
                end
                FILL: begin
                    if (rinc) begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt == LAST_IDX) begin
                            state_reg  <= STREAM;
                            out_valid  <= 1'b1;
                            rd_idx_reg <= '0;
                        end
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (last_xfer) begin
                            out_valid <= 1'b0;
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end else begin
                            rd_idx_reg <= rd_idx_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench with a FIFO model, an expected-word scoreboard and a decoupled stream monitor.
module tb_fifo_burst_reader;

    localparam int DSIZE = 8;
    localparam int BURST = 16;
    localparam int CW    = 9;

    logic             rclk = 1'b0;
    logic             rrst_n;
    logic             start;
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic [DSIZE-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [CW-1:0]    fill_cnt;

    always #5 rclk = ~rclk;

    fifo_burst_reader #(.DSIZE(DSIZE), .BURST(BURST), .CW(CW)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .start     (start),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .fill_cnt  (fill_cnt)
    );

    // FIFO model: stimulus advances wr_ptr away from edges, pops advance rd_ptr on the edge.
    logic [DSIZE-1:0] fifo_mem [256];
    int               wr_ptr = 0;
    int               rd_ptr = 0;
    logic             flush  = 1'b0;
    logic [7:0]       rd_slot;

    assign rd_slot = rd_ptr[7:0];
    assign rempty  = (rd_ptr == wr_ptr);
    assign rdata   = fifo_mem[rd_slot];

    always @(posedge rclk) begin
        if (flush)     rd_ptr <= wr_ptr;
        else if (rinc) rd_ptr <= rd_ptr + 1;
    end

    logic [DSIZE-1:0] exp_q [$];
    int vectors       = 0;
    int miscompares   = 0;
    int cyc           = 0;
    int tcyc          = 0;
    int burst_pops    = 0;
    int first_pop_cyc = 0;
    int last_xfer_cyc = -10;
    int done_cyc      = 0;
    int done_cnt      = 0;
    int xfer_cnt      = 0;
    int trickle_left  = 0;
    int trickle_val   = 0;
    logic bp_mode     = 1'b0;
    logic [3:0] bp_pat = 4'b1001;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int w, input bit expect_out);
        logic [7:0] slot;
        slot = wr_ptr[7:0];
        fifo_mem[slot] = DSIZE'(w);
        wr_ptr++;
        if (expect_out) exp_q.push_back(DSIZE'(w));
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
        tcyc++;
        if (bp_mode) out_ready = bp_pat[tcyc % 4];
        if (trickle_left > 0 && (tcyc % 5) == 0) begin
            push(trickle_val, 1'b1);
            trickle_val++;
            trickle_left--;
        end
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        check("done_within_budget", int'(done_cnt != d0), 1);
    endtask

    task automatic run_burst(input int budget);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(budget);
    endtask

    task automatic monitor();
        logic             prev_stall;
        logic [DSIZE-1:0] prev_data;
        logic [DSIZE-1:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge rclk);
            cyc++;
            if (rinc) begin
                if (burst_pops == 0) first_pop_cyc = cyc;
                burst_pops++;
            end
            if (rinc && rempty) begin
                miscompares++;
                $display("FAIL rinc_when_empty: rinc=1 with rempty=1 (cycle %0d)", cyc);
            end
            if (rinc && (out_valid || done)) begin
                miscompares++;
                $display("FAIL rinc_outside_fill: rinc=1 with out_valid=%0b done=%0b (cycle %0d)",
                         out_valid, done, cyc);
            end
            if (prev_stall && rrst_n) begin
                check("stall_valid_held", int'(out_valid), 1);
                check("stall_data_held", int'(out_data), int'(prev_data));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                xfer_cnt++;
                last_xfer_cyc = cyc;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no transfer (cycle %0d)",
                             out_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_data", int'(out_data), int'(e));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_after_last_xfer", cyc, last_xfer_cyc + 1);
            end
        end
    endtask

    initial begin
        int d0;
        int d1;
        int x0;
        int n;
        for (int i = 0; i < 256; i++) fifo_mem[i] = '0;
        rrst_n    = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) step();
        check("reset_busy", int'(busy), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_done", int'(done), 0);
        check("reset_rinc", int'(rinc), 0);
        check("reset_fill_cnt", int'(fill_cnt), 0);
        rrst_n = 1'b1;
        step();

        // Basic burst: 16 back-to-back pops, 16 back-to-back transfers, done right after
        burst_pops = 0;
        for (int i = 0; i < BURST; i++) push(i, 1'b1);
        run_burst(100);
        check("basic_pops", burst_pops, BURST);
        check("basic_fill_cnt", int'(fill_cnt), BURST);
        check("basic_first_pop_to_done", done_cyc - first_pop_cyc, 2 * BURST);
        check("basic_scoreboard_empty", exp_q.size(), 0);

        // Empty stall: one word every 5 cycles
        burst_pops   = 0;
        trickle_val  = 'h20;
        trickle_left = BURST;
        run_burst(300);
        check("stall_pops", burst_pops, BURST);
        check("stall_scoreboard_empty", exp_q.size(), 0);

        // Backpressure: out_ready 1,0,0,1 repeating
        burst_pops = 0;
        x0 = xfer_cnt;
        for (int i = 0; i < BURST; i++) push('h40 + i, 1'b1);
        bp_mode = 1'b1;
        run_burst(200);
        bp_mode   = 1'b0;
        out_ready = 1'b1;
        check("bp_pops", burst_pops, BURST);
        check("bp_transfers", xfer_cnt - x0, BURST);
        check("bp_scoreboard_empty", exp_q.size(), 0);

        // Over-full FIFO: 20 queued, only the first 16 popped
        burst_pops = 0;
        for (int i = 0; i < 20; i++) push('h80 + i, i < BURST);
        run_burst(100);
        repeat (2) step();
        check("overfull_pops", burst_pops, BURST);
        check("overfull_rempty", int'(rempty), 0);
        check("overfull_next_word", int'(rdata), 'h90);
        check("overfull_scoreboard_empty", exp_q.size(), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_rempty", int'(rempty), 1);

        // Reset mid-fill at fill_cnt=7; the word popped on the reset edge is lost
        for (int i = 0; i < 24; i++) push('hA0 + i, i >= 8);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (fill_cnt != 7 && n < 50) begin
            step();
            n++;
        end
        check("midreset_reached_fill7", int'(fill_cnt), 7);
        d0 = done_cnt;
        rrst_n = 1'b0;
        step();
        rrst_n = 1'b1;
        check("midreset_busy", int'(busy), 0);
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_fill_cnt", int'(fill_cnt), 0);
        repeat (3) step();
        check("midreset_no_done", done_cnt - d0, 0);
        check("midreset_idle_no_pop", int'(rinc), 0);
        burst_pops = 0;
        run_burst(100);
        check("midreset_resume_pops", burst_pops, BURST);
        check("midreset_scoreboard_empty", exp_q.size(), 0);
        check("midreset_fifo_drained", int'(rempty), 1);

        // Back-to-back bursts with start held high
        for (int i = 0; i < 2 * BURST; i++) push('hC0 + i, 1'b1);
        start = 1'b1;
        wait_done(100);
        d1 = done_cyc;
        wait_done(100);
        start = 1'b0;
        check("b2b_done_spacing", done_cyc - d1, 2 * BURST + 2);
        check("b2b_scoreboard_empty", exp_q.size(), 0);
        repeat (3) step();
        check("b2b_idle_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
